// File: rtl/demux1_8_deser.sv
// Serial-in, parallel-out 1:8 demultiplexer. Bits fill slots 0..7 (LSB first) and each
// finished byte is registered to q with a one-cycle out_valid. Optional PARITY_CHK_EN adds an even-parity bit per word.
module demux1_8_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       start,
  output logic [7:0] q,
  output logic       out_valid,
  output logic [2:0] sel,
  output logic       busy,
  output logic       parity_err
);

  localparam int N_OUT = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1
`ifdef PARITY_CHK_EN
    ,PARITY = 2'd2
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_OUT-1:0]   shadow_q, shadow_d;
  logic [N_OUT-1:0]   q_q, q_d;
  logic               out_valid_q, out_valid_d;
  logic               parity_err_q, parity_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      shadow_q     <= '0;
      q_q          <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      q_q          <= q_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    q_d          = q_q;
    out_valid_d  = 1'b0;
    parity_err_d = 1'b0;
    if (start) begin
      // Resync drops the partial word; a bit presented alongside start becomes bit 0.
      shadow_d = '0;
      if (din_valid) begin
        shadow_d[0] = din;
        sel_d       = SEL_W'(1);
        state_d     = COLLECT;
      end else begin
        sel_d   = '0;
        state_d = IDLE;
      end
    end else if (din_valid) begin
      case (state_q)
        IDLE: begin
          shadow_d[0] = din;
          sel_d       = SEL_W'(1);
          state_d     = COLLECT;
        end
        COLLECT: begin
          shadow_d[sel_q] = din;
          if (sel_q == SEL_W'(N_OUT - 1)) begin
            sel_d = '0;
`ifdef PARITY_CHK_EN
            state_d = PARITY;
`else
            q_d         = shadow_d;
            out_valid_d = 1'b1;
            state_d     = IDLE;
`endif
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
`ifdef PARITY_CHK_EN
        PARITY: begin
          q_d          = shadow_q;
          out_valid_d  = 1'b1;
          parity_err_d = (^shadow_q) ^ din;
          sel_d        = '0;
          state_d      = IDLE;
        end
`endif
        default: begin
          sel_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign q         = q_q;
  assign out_valid = out_valid_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);
`ifdef PARITY_CHK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux1_8_deser.sv
// Randomised plus directed bench for demux1_8_deser; a bit-queue model predicts words,
// sel and busy, and a negedge monitor checks every cycle. Honours PARITY_CHK_EN.
module tb_demux1_8_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       start = 1'b0;
  logic [7:0] q;
  logic       out_valid;
  logic [2:0] sel;
  logic       busy;
  logic       parity_err;

  demux1_8_deser dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .start      (start),
    .q          (q),
    .out_valid  (out_valid),
    .sel        (sel),
    .busy       (busy),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

`ifdef PARITY_CHK_EN
  localparam int WLEN = 9;
`else
  localparam int WLEN = 8;
`endif

  // Model: bits collected so far, expected output words {parity_err, q}, expected held q.
  logic       bits[$];
  logic [8:0] exp_q[$];
  logic [7:0] model_q = 8'h00;
  bit         chk_en = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the same edge the DUT samples.
  task automatic step(input logic r, input logic s, input logic v, input logic d);
    logic [7:0] w;
    logic       pe;
    rst = r; start = s; din_valid = v; din = d;
    @(posedge clk);
    if (r) begin
      bits.delete();
      model_q = 8'h00;
    end else begin
      if (s) bits.delete();
      if (v) begin
        bits.push_back(d);
        if (bits.size() == WLEN) begin
          for (int i = 0; i < 8; i++) w[i] = bits[i];
          pe = (WLEN == 9) ? ((^w) ^ bits[WLEN-1]) : 1'b0;
          exp_q.push_back({pe, w});
          model_q = w;
          bits.delete();
        end
      end
    end
    #1;
    rst = 1'b0; start = 1'b0; din_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, b[i]);
`ifdef PARITY_CHK_EN
    step(1'b0, 1'b0, 1'b1, ^b);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: word pulses are scoreboarded; sel, busy and held q checked every cycle.
  always @(negedge clk) begin
    logic [8:0] e;
    if (chk_en) begin
      if (out_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("word_q", {24'd0, q}, {24'd0, e[7:0]});
          check("word_parity_err", {31'd0, parity_err}, {31'd0, e[8]});
        end
      end else begin
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          check("missing_out_valid", 32'd0, 32'd1);
        end
        check("parity_err_idle", {31'd0, parity_err}, 32'd0);
      end
      check("q_hold", {24'd0, q}, {24'd0, model_q});
      check("sel", {29'd0, sel}, (bits.size() >= 8) ? 32'd0 : bits.size());
      check("busy", {31'd0, busy}, {31'd0, bits.size() != 0});
    end
  end

  initial begin
    logic [7:0] aa;
    aa = 8'hAA;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_q", {24'd0, q}, 32'h00);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_sel", {29'd0, sel}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    send_byte(8'hAA);
    idle(2);
    // Same byte with a 3-cycle gap between bits 2 and 3.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, aa[i]);
      if (i == 2) idle(3);
    end
`ifdef PARITY_CHK_EN
    step(1'b0, 1'b0, 1'b1, ^aa);
`endif
    idle(2);
    // Partial word discarded by start, then a full 0x5A.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h5A);
    idle(1);
    // Back-to-back words.
    send_byte(8'h0F);
    send_byte(8'hF0);
    idle(1);
    // Reset mid-word.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h3C);
    // start together with a valid bit keeps that bit as bit 0.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < WLEN - 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
`ifdef PARITY_CHK_EN
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, aa[i]);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    aa = 8'hAB;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, aa[i]);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
    end
    idle(2);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("pulses_seen_nonzero", {31'd0, pulses > 8}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
